// File: rtl/async_fifo_pkg.sv
// Shared definitions for the stream FIFO: depth derivation and Gray-code helpers
// used by the pointer logic so it carries over unchanged to a dual-clock build.
package async_fifo_pkg;

  localparam int unsigned PTR_MAX_W = 16;

  // Wide pointer container; users cast down to ADDR_WIDTH+1 bits.
  typedef logic [PTR_MAX_W-1:0] ptr_t;

  function automatic int unsigned depth_of(input int unsigned addr_width);
    return 32'd1 << addr_width;
  endfunction

  function automatic ptr_t bin2gray(input ptr_t b);
    return b ^ (b >> 1);
  endfunction

  function automatic ptr_t gray2bin(input ptr_t g);
    ptr_t b;
    b = g;
    for (int unsigned i = 1; i < PTR_MAX_W; i++) begin
      b = b ^ (g >> i);
    end
    return b;
  endfunction

endpackage

// File: rtl/fifo_ram.sv
// DEPTH x DATA_WIDTH storage: synchronous write port, combinational read port, no reset.
module fifo_ram #(
  parameter int unsigned ADDR_WIDTH = 2,
  parameter int unsigned DATA_WIDTH = 128
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic [ADDR_WIDTH-1:0] waddr,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic [ADDR_WIDTH-1:0] raddr,
  output logic [DATA_WIDTH-1:0] rdata
);
  import async_fifo_pkg::*;

  localparam int unsigned DEPTH = depth_of(ADDR_WIDTH);

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/async_fifo_core.sv
// First-word-fall-through stream FIFO with valid/ready on both sides.
// Pointers are held in Gray code with a wrap bit; flags are registered from next-state pointers.
module async_fifo_core #(
  parameter int unsigned ADDR_WIDTH = 2,
  parameter int unsigned DATA_WIDTH = 128
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  write_tvalid,
  output logic                  write_tready,
  input  logic [DATA_WIDTH-1:0] write_data,
  input  logic                  read_tready,
  output logic                  read_tvalid,
  output logic [DATA_WIDTH-1:0] read_data
);
  import async_fifo_pkg::*;

  localparam int unsigned PW = ADDR_WIDTH + 1;

  logic [PW-1:0] wr_gray_q;
  logic [PW-1:0] rd_gray_q;
  logic [PW-1:0] wr_bin;
  logic [PW-1:0] rd_bin;
  logic [PW-1:0] wr_bin_nxt;
  logic [PW-1:0] rd_bin_nxt;
  logic [PW-1:0] wr_gray_nxt;
  logic [PW-1:0] rd_gray_nxt;
  logic          wr_fire;
  logic          rd_fire;
  logic          full_nxt;
  logic          empty_nxt;

  assign wr_fire = write_tvalid && write_tready;
  assign rd_fire = read_tready && read_tvalid;

  always_comb begin
    wr_bin      = PW'(gray2bin(ptr_t'(wr_gray_q)));
    rd_bin      = PW'(gray2bin(ptr_t'(rd_gray_q)));
    wr_bin_nxt  = wr_bin + {{ADDR_WIDTH{1'b0}}, wr_fire};
    rd_bin_nxt  = rd_bin + {{ADDR_WIDTH{1'b0}}, rd_fire};
    wr_gray_nxt = PW'(bin2gray(ptr_t'(wr_bin_nxt)));
    rd_gray_nxt = PW'(bin2gray(ptr_t'(rd_bin_nxt)));
    // Flags come from the post-edge pointers so both ports see registered state only.
    empty_nxt   = (wr_bin_nxt == rd_bin_nxt);
    full_nxt    = (wr_bin_nxt[ADDR_WIDTH-1:0] == rd_bin_nxt[ADDR_WIDTH-1:0]) &&
                  (wr_bin_nxt[ADDR_WIDTH] != rd_bin_nxt[ADDR_WIDTH]);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_gray_q    <= '0;
      rd_gray_q    <= '0;
      write_tready <= 1'b0;
      read_tvalid  <= 1'b0;
    end else begin
      wr_gray_q    <= wr_gray_nxt;
      rd_gray_q    <= rd_gray_nxt;
      write_tready <= !full_nxt;
      read_tvalid  <= !empty_nxt;
    end
  end

  fifo_ram #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .DATA_WIDTH (DATA_WIDTH)
  ) u_ram (
    .clk   (clk),
    .we    (wr_fire),
    .waddr (wr_bin[ADDR_WIDTH-1:0]),
    .wdata (write_data),
    .raddr (rd_bin[ADDR_WIDTH-1:0]),
    .rdata (read_data)
  );

endmodule

// File: tb/tb_async_fifo_core.sv
// Self-checking bench for async_fifo_core: directed fill/drain/reset cases plus a random soak,
// all checked against a queue-based reference of a DEPTH-word in-order FIFO.
module tb_async_fifo_core;

  localparam int unsigned AW    = 2;
  localparam int unsigned DW    = 128;
  localparam int unsigned DEPTH = 4;
  localparam int unsigned SOAK_WORDS = 11000;

  logic          clk;
  logic          reset_n;
  logic          write_tvalid;
  logic          write_tready;
  logic [DW-1:0] write_data;
  logic          read_tready;
  logic          read_tvalid;
  logic [DW-1:0] read_data;

  int unsigned checks   = 0;
  int unsigned failures = 0;

  logic [DW-1:0] q[$];
  logic          started;
  logic          last_push;
  logic          last_pop;

  async_fifo_core #(
    .ADDR_WIDTH (AW),
    .DATA_WIDTH (DW)
  ) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .write_tvalid (write_tvalid),
    .write_tready (write_tready),
    .write_data   (write_data),
    .read_tready  (read_tready),
    .read_tvalid  (read_tvalid),
    .read_data    (read_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [DW-1:0] rand_word();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  // One clock cycle: compare outputs against the reference mid-cycle, then apply the edge.
  task automatic step();
    logic push;
    logic pop;
    @(negedge clk);
    chk("wready", write_tready, (started && q.size() < DEPTH) ? 1'b1 : 1'b0);
    chk("rvalid", read_tvalid, (q.size() > 0) ? 1'b1 : 1'b0);
    if (q.size() > 0) chk("rdata", read_data, q[0]);
    push = write_tvalid && started && (q.size() < DEPTH);
    pop  = read_tready && (q.size() > 0);
    @(posedge clk);
    if (pop) void'(q.pop_front());
    if (push) q.push_back(write_data);
    started   = 1'b1;
    last_push = push;
    last_pop  = pop;
    #1;
  endtask

  task automatic do_reset();
    reset_n      = 1'b0;
    write_tvalid = 1'b0;
    read_tready  = 1'b0;
    #2;
    chk("rst_wready", write_tready, 1'b0);
    chk("rst_rvalid", read_tvalid, 1'b0);
    q.delete();
    started = 1'b0;
    @(posedge clk);
    #1;
    chk("rst_hold_wready", write_tready, 1'b0);
    reset_n = 1'b1;
    #1;
    chk("rel_wready", write_tready, 1'b0);
    chk("rel_rvalid", read_tvalid, 1'b0);
  endtask

  logic [DW-1:0] a_words [5];
  logic [DW-1:0] b_words [5];
  logic [DW-1:0] c_words [3];
  logic [DW-1:0] d_word;
  int unsigned   sent;
  int unsigned   popped;
  int unsigned   cycles;

  initial begin
    reset_n      = 1'b0;
    write_tvalid = 1'b0;
    read_tready  = 1'b0;
    write_data   = '0;
    started      = 1'b0;
    last_push    = 1'b0;
    last_pop     = 1'b0;
    for (int i = 0; i < 5; i++) begin
      a_words[i] = rand_word();
      b_words[i] = rand_word();
    end
    for (int i = 0; i < 3; i++) c_words[i] = rand_word();
    d_word = rand_word();

    // Reset and first edge after release.
    do_reset();
    step();
    chk("first_wready", write_tready, 1'b1);
    chk("first_rvalid", read_tvalid, 1'b0);

    // Fill with consumer stalled.
    for (int i = 0; i < 4; i++) begin
      write_tvalid = 1'b1;
      write_data   = a_words[i];
      step();
    end
    chk("fill_full", write_tready, 1'b0);
    write_data = a_words[4];
    step();
    step();
    chk("fill_still_full", write_tready, 1'b0);

    // Drain; the held fifth word is still offered during the first pop and must be dropped.
    read_tready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      chk("drain_order", read_data, a_words[i]);
      chk("drain_valid", read_tvalid, 1'b1);
      step();
      write_tvalid = 1'b0;
      if (i == 0) chk("wready_after_pop", write_tready, 1'b1);
    end
    chk("drain_empty", read_tvalid, 1'b0);
    step();
    chk("drain_no_extra", read_tvalid, 1'b0);
    read_tready = 1'b0;

    // Push+pop with two stored words keeps occupancy at two.
    for (int i = 0; i < 2; i++) begin
      write_tvalid = 1'b1;
      write_data   = b_words[i];
      step();
    end
    read_tready = 1'b1;
    for (int i = 2; i < 5; i++) begin
      write_data = b_words[i];
      chk("pp_order", read_data, b_words[i-2]);
      step();
      chk("pp_occupancy", q.size(), 2);
      chk("pp_wready", write_tready, 1'b1);
    end
    write_tvalid = 1'b0;
    for (int i = 3; i < 5; i++) begin
      chk("pp_tail", read_data, b_words[i]);
      step();
    end
    chk("pp_empty", read_tvalid, 1'b0);
    read_tready = 1'b0;

    // Reset with three words stored discards them.
    for (int i = 0; i < 3; i++) begin
      write_tvalid = 1'b1;
      write_data   = c_words[i];
      step();
    end
    chk("mid_rvalid_before", read_tvalid, 1'b1);
    do_reset();
    step();
    write_tvalid = 1'b1;
    write_data   = d_word;
    step();
    write_tvalid = 1'b0;
    chk("mid_rvalid_after", read_tvalid, 1'b1);
    chk("mid_first_word", read_data, d_word);
    read_tready = 1'b1;
    step();
    read_tready = 1'b0;
    chk("mid_empty", read_tvalid, 1'b0);

    // Random soak against the reference queue.
    do_reset();
    sent      = 0;
    popped    = 0;
    cycles    = 0;
    last_push = 1'b0;
    while (popped < SOAK_WORDS && cycles < 90000) begin
      if (last_push || !write_tvalid) begin
        write_tvalid = (sent < SOAK_WORDS) ? 1'($urandom_range(0, 1)) : 1'b0;
        if (write_tvalid) write_data = rand_word();
      end
      read_tready = (q.size() > 0) && 1'($urandom_range(0, 1));
      step();
      if (last_push) sent++;
      if (last_pop) popped++;
      cycles++;
    end
    write_tvalid = 1'b0;
    read_tready  = 1'b0;
    chk("soak_sent", sent, SOAK_WORDS);
    chk("soak_popped", popped, SOAK_WORDS);
    chk("soak_left", q.size(), 0);
    step();
    chk("soak_end_rvalid", read_tvalid, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
